// File: rtl/lfsr_prng_stream.sv
// lfsr_prng_stream: Fibonacci LFSR word generator with valid/ready output, run-time seeding and en gating.
// Optional zero-seed substitution and lockup pulse enabled by defining LFSR_ZERO_GUARD_EN.
module lfsr_prng_stream #(
  parameter int DATA_LEN = 8,
  parameter int LFSR_LEN = 16,
  parameter logic [LFSR_LEN-1:0] TAPS = 16'hB400,
  parameter logic [LFSR_LEN-1:0] SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                seed_load,
  input  logic [LFSR_LEN-1:0] seed_in,
  output logic                rnd_valid,
  input  logic                rnd_ready,
  output logic [DATA_LEN-1:0] rnd_num,
  output logic [LFSR_LEN-1:0] lfsr_state,
  output logic                lockup
);
  localparam int CW = DATA_LEN > 1 ? $clog2(DATA_LEN) : 1;
  typedef enum logic {FILL, HOLD} state_t;
  state_t state, state_d;
  logic [LFSR_LEN-1:0] lfsr, lfsr_nx, load_val;
  logic [CW-1:0] cnt;
  logic fb, step, last, accept;
  assign fb = ^(lfsr & TAPS);
  assign lfsr_nx = {lfsr[LFSR_LEN-2:0], fb};
  assign step = state == FILL && en;
  assign last = cnt == CW'(DATA_LEN - 1);
  assign accept = state == HOLD && rnd_ready;
`ifdef LFSR_ZERO_GUARD_EN
  logic zero_seed;
  assign zero_seed = seed_in == '0;
  assign load_val = zero_seed ? SEED : seed_in;
  always_ff @(posedge clk)
    lockup <= rst ? 1'b0 : seed_load && zero_seed;
`else
  assign load_val = seed_in;
  assign lockup = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst || seed_load ? FILL : state_d;
  always_comb
    state_d = step && last ? HOLD : accept ? FILL : state;
  always_comb begin
    rnd_valid = state == HOLD;
    lfsr_state = lfsr;
  end
  // the completed word is taken from the post-step value so all DATA_LEN bits are fresh feedback
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
      cnt <= '0;
      rnd_num <= '0;
    end else if (seed_load) begin
      lfsr <= load_val;
      cnt <= '0;
    end else if (step) begin
      lfsr <= lfsr_nx;
      cnt <= last ? '0 : cnt + CW'(1);
      if (last) rnd_num <= lfsr_nx[DATA_LEN-1:0];
    end
  end
endmodule

// File: tb/tb_lfsr_prng_stream.sv
// tb_lfsr_prng_stream: directed plan steps plus randomized traffic checked against a bit-stream reference model.
module tb_lfsr_prng_stream;
  logic clk = 0, rst = 1, en = 1, seed_load = 0, rnd_ready = 1;
  logic [15:0] seed_in = '0;
  logic rnd_valid, lockup;
  logic [7:0] rnd_num;
  logic [15:0] lfsr_state;
  int n_cmp = 0, n_err = 0;
  logic [15:0] m_lfsr, taps = 16'hB400;
  logic [7:0] m_word, m_acc;
  logic m_valid, m_lock;
  int m_bits;

  lfsr_prng_stream dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_num(rnd_num),
    .lfsr_state(lfsr_state), .lockup(lockup)
  );

  always #5 clk = ~clk;

  function automatic logic parity(input logic [15:0] s);
    logic b = 0;
    for (int i = 0; i < 16; i++) if (taps[i]) b ^= s[i];
    return b;
  endfunction

  // reference: words are consecutive groups of eight fresh feedback bits
  task automatic tick();
    logic b;
    m_lock = 0;
    if (rst) begin
      m_lfsr = 16'hACE1; m_bits = 0; m_valid = 0; m_word = 0; m_acc = 0;
    end else if (seed_load) begin
`ifdef LFSR_ZERO_GUARD_EN
      m_lfsr = seed_in == 0 ? 16'hACE1 : seed_in;
      m_lock = seed_in == 0;
`else
      m_lfsr = seed_in;
`endif
      m_bits = 0; m_valid = 0;
    end else if (m_valid) begin
      if (rnd_ready) m_valid = 0;
    end else if (en) begin
      b = parity(m_lfsr);
      m_lfsr = {m_lfsr[14:0], b};
      m_acc = {m_acc[6:0], b};
      m_bits++;
      if (m_bits == 8) begin m_valid = 1; m_word = m_acc; m_bits = 0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    // reset state and first word
    do_reset();
    chk("rst_valid", 16'(rnd_valid), 16'd0);
    chk("rst_num", 16'(rnd_num), 16'h00);
    chk("rst_lfsr", lfsr_state, 16'hACE1);
    ticks(7);
    chk("w1_early", 16'(rnd_valid), 16'd0);
    tick();
    chk("w1_valid", 16'(rnd_valid), 16'd1);
    chk("w1_num", 16'(rnd_num), 16'hE4);
    chk("w1_lfsr", lfsr_state, 16'hE1E4);
    tick();
    chk("w1_drop", 16'(rnd_valid), 16'd0);
    // backpressure holds the word and freezes the LFSR
    do_reset();
    rnd_ready = 0;
    ticks(8);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_num", 16'(rnd_num), 16'hE4);
      chk("bp_valid", 16'(rnd_valid), 16'd1);
      chk("bp_lfsr", lfsr_state, 16'hE1E4);
    end
    rnd_ready = 1;
    ticks(8);
    chk("bp_next_early", 16'(rnd_valid), 16'd0);
    tick();
    chk("bp_next_valid", 16'(rnd_valid), 16'd1);
    chk("bp_next_num", 16'(rnd_num), 16'(m_word));
    // en toggling halves the rate
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      en = (i % 2) == 0;
      tick();
      if (i == 15) chk("tog_early", 16'(rnd_valid), 16'd0);
    end
    chk("tog_valid", 16'(rnd_valid), 16'd1);
    chk("tog_num", 16'(rnd_num), 16'hE4);
    en = 1;
    // seed_load mid-fill discards the partial word
    do_reset();
    ticks(5);
    seed_load = 1; seed_in = 16'hACE1; tick(); seed_load = 0;
    chk("sl_lfsr", lfsr_state, 16'hACE1);
    ticks(7);
    chk("sl_early", 16'(rnd_valid), 16'd0);
    tick();
    chk("sl_valid", 16'(rnd_valid), 16'd1);
    chk("sl_num", 16'(rnd_num), 16'hE4);
    // zero seed
    seed_load = 1; seed_in = 16'h0000; tick(); seed_load = 0;
`ifdef LFSR_ZERO_GUARD_EN
    chk("z_lock", 16'(lockup), 16'd1);
    chk("z_lfsr", lfsr_state, 16'hACE1);
    tick();
    chk("z_lock_end", 16'(lockup), 16'd0);
    ticks(7);
    chk("z_num", 16'(rnd_num), 16'hE4);
`else
    chk("z_lock", 16'(lockup), 16'd0);
    chk("z_lfsr", lfsr_state, 16'h0000);
    ticks(8);
    chk("z_lfsr_stuck", lfsr_state, 16'h0000);
    chk("z_num", 16'(rnd_num), 16'h00);
`endif
    chk("z_valid", 16'(rnd_valid), 16'd1);
    // reset while holding a word
    rnd_ready = 0;
    ticks(3);
    do_reset();
    chk("rh_valid", 16'(rnd_valid), 16'd0);
    chk("rh_num", 16'(rnd_num), 16'h00);
    chk("rh_lfsr", lfsr_state, 16'hACE1);
    rnd_ready = 1;
    ticks(8);
    chk("rh_num2", 16'(rnd_num), 16'hE4);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      en = $urandom_range(3) != 0;
      rnd_ready = $urandom_range(1) == 1;
      seed_load = $urandom_range(40) == 0;
      seed_in = $urandom_range(5) == 0 ? 16'h0 : 16'($urandom);
      tick();
      chk("rnd_valid", 16'(rnd_valid), 16'(m_valid));
      chk("rnd_num", 16'(rnd_num), 16'(m_word));
      chk("rnd_lfsr", lfsr_state, m_lfsr);
      chk("rnd_lock", 16'(lockup), 16'(m_lock));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
